hash_msg_feeder: RTL and testbench

- Upstream feeder for the DES-S-box hash core.
- Buffers one complete message from a byte-stream host interface and counts its length, so the core has the total byte counter from the first byte onward.
- Replays the buffered bytes to the core, one `msg_valid` pulse every `BYTE_PERIOD` cycles, then waits for the core's `hash_ready` before taking the next message.

---
 rtl/hash_msg_feeder.sv | 156 +++++++++++++++
 tb/tb_hash_msg_feeder.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hash_msg_feeder.sv
// Message feeder for the DES-S-box hash core: buffers one host message, then replays
// it byte by byte at the core's cadence and waits for hash_ready before taking the next.
module hash_msg_feeder #(
  parameter int DEPTH       = 64,
  parameter int BYTE_PERIOD = 4,
  parameter int AW          = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic [7:0]  msg_byte,
  output logic        msg_valid,
  output logic [63:0] msg_length,
  input  logic        hash_ready_i,
  output logic        busy,
  output logic        done,
  output logic        err_overflow
);

  localparam int            GW       = $clog2(BYTE_PERIOD);
  localparam logic [AW:0]   LEN_LAST = (AW+1)'(DEPTH - 1);
  localparam logic [GW-1:0] GAP_INIT = GW'(BYTE_PERIOD - 2);

  typedef enum logic [2:0] {LOAD, DRAIN, FEED, GAP, WAIT_DIGEST} state_t;

  state_t        state_q, state_d;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]   len_q, len_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0]    msg_byte_q, msg_byte_d;
  logic          msg_valid_q, msg_valid_d;
  logic [63:0]   msg_length_q, msg_length_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          accept;
  logic          mem_we;

  // in_ready is forced low during reset even though the state register already reads LOAD.
  assign in_ready = ~rst & ((state_q == LOAD) | (state_q == DRAIN));
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= LOAD;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD: begin
        if (accept) begin
          if (in_last)                state_d = FEED;
          else if (len_q == LEN_LAST) state_d = DRAIN;
        end
      end
      DRAIN:       if (accept && in_last) state_d = LOAD;
      FEED:        state_d = GAP;
      GAP:         if (gap_q == '0) state_d = (rd_ptr_q == len_q) ? WAIT_DIGEST : FEED;
      WAIT_DIGEST: if (hash_ready_i) state_d = LOAD;
      default:     state_d = LOAD;
    endcase
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    len_d        = len_q;
    gap_d        = gap_q;
    msg_byte_d   = msg_byte_q;
    msg_valid_d  = 1'b0;
    msg_length_d = msg_length_q;
    done_d       = 1'b0;
    err_d        = err_q;
    mem_we       = 1'b0;
    case (state_q)
      LOAD: begin
        if (accept) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
          len_d    = len_q + (AW+1)'(1);
          if (in_last)                msg_length_d = 64'(len_q) + 64'd1;
          else if (len_q == LEN_LAST) err_d = 1'b1;
        end
      end
      DRAIN: begin
        if (accept && in_last) begin
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          len_d    = '0;
        end
      end
      FEED: begin
        msg_byte_d  = mem[rd_ptr_q[AW-1:0]];
        msg_valid_d = 1'b1;
        rd_ptr_d    = rd_ptr_q + (AW+1)'(1);
        gap_d       = GAP_INIT;
      end
      GAP: if (gap_q != '0) gap_d = gap_q - GW'(1);
      WAIT_DIGEST: begin
        if (hash_ready_i) begin
          done_d   = 1'b1;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          len_d    = '0;
        end
      end
      default: ;
    endcase
    busy_d = (state_d != LOAD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      len_q        <= '0;
      gap_q        <= '0;
      msg_byte_q   <= '0;
      msg_valid_q  <= 1'b0;
      msg_length_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      len_q        <= len_d;
      gap_q        <= gap_d;
      msg_byte_q   <= msg_byte_d;
      msg_valid_q  <= msg_valid_d;
      msg_length_q <= msg_length_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  // Buffer contents are never reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_q] <= in_data;
  end

  assign msg_byte     = msg_byte_q;
  assign msg_valid    = msg_valid_q;
  assign msg_length   = msg_length_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err_overflow = err_q;

endmodule

// File: tb/tb_hash_msg_feeder.sv
// Bench for hash_msg_feeder: two instances (DEPTH=4/period 4 and DEPTH=16/period 6)
// checked against a timing/byte-order model built from the feeder's external rules.
module tb_hash_msg_feeder;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int          d;
    int          edge_n;
    logic [7:0]  b;
    logic [63:0] len;
  } pulse_t;

  logic        clk = 1'b0;
  logic        rst          [2];
  logic        in_valid     [2];
  logic [7:0]  in_data      [2];
  logic        in_last      [2];
  logic        in_ready     [2];
  logic [7:0]  msg_byte     [2];
  logic        msg_valid    [2];
  logic [63:0] msg_length   [2];
  logic        hash_ready_i [2];
  logic        busy         [2];
  logic        done         [2];
  logic        err_overflow [2];

  int     n_checks = 0;
  int     n_errs   = 0;
  int     cyc      = 0;
  pulse_t pulse_q[$];

  hash_msg_feeder #(.DEPTH(4), .BYTE_PERIOD(4)) u0 (
    .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_data(in_data[0]),
    .in_last(in_last[0]), .in_ready(in_ready[0]), .msg_byte(msg_byte[0]),
    .msg_valid(msg_valid[0]), .msg_length(msg_length[0]), .hash_ready_i(hash_ready_i[0]),
    .busy(busy[0]), .done(done[0]), .err_overflow(err_overflow[0])
  );

  hash_msg_feeder #(.DEPTH(16), .BYTE_PERIOD(6)) u1 (
    .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_data(in_data[1]),
    .in_last(in_last[1]), .in_ready(in_ready[1]), .msg_byte(msg_byte[1]),
    .msg_valid(msg_valid[1]), .msg_length(msg_length[1]), .hash_ready_i(hash_ready_i[1]),
    .busy(busy[1]), .done(done[1]), .err_overflow(err_overflow[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // cyc at a negedge is the index of the edge that produced the sampled outputs.
  always @(negedge clk) begin
    pulse_t p;
    for (int d = 0; d < 2; d++) begin
      if (msg_valid[d] === 1'b1) begin
        p.d = d; p.edge_n = cyc; p.b = msg_byte[d]; p.len = msg_length[d];
        pulse_q.push_back(p);
      end
    end
  end

  function automatic int per(input int d);
    return (d == 0) ? 4 : 6;
  endfunction

  function automatic int count_p(input int d);
    int c = 0;
    foreach (pulse_q[i]) if (pulse_q[i].d == d) c++;
    return c;
  endfunction

  task automatic send_msg(input int d, input bq_t msg, input bit rnd, input bit last_on_end,
                          output int last_edge);
    int i = 0;
    int guard = 0;
    bit acc;
    last_edge = -1;
    while (i < msg.size() && guard < 2000) begin
      @(negedge clk);
      if (rnd && $urandom_range(0, 2) == 0) begin
        in_valid[d] = 1'b0; in_data[d] = 8'($urandom); in_last[d] = 1'($urandom);
      end else begin
        in_valid[d] = 1'b1; in_data[d] = msg[i];
        in_last[d]  = last_on_end && (i == msg.size() - 1);
      end
      acc = (in_valid[d] === 1'b1) && (in_ready[d] === 1'b1);
      if (acc) begin
        if (i == msg.size() - 1) last_edge = cyc + 1;
        i++;
      end
      guard++;
    end
    n_checks++;
    if (i != msg.size()) begin
      n_errs++;
      $display("FAIL send_dut%0d accepted=%0d required=%0d", d, i, msg.size());
    end
    @(negedge clk);
    in_valid[d] = 1'b0; in_last[d] = 1'b0;
  endtask

  task automatic check_feed(input int d, input bq_t msg, input int last_edge, input bit exp_err,
                            input string nm);
    pulse_t got[$];
    int guard = 0;
    int n = msg.size();
    while (count_p(d) < n && guard < (n + 2) * per(d) + 10) begin
      @(negedge clk); guard++;
    end
    repeat (2 * per(d)) @(negedge clk);
    foreach (pulse_q[i]) if (pulse_q[i].d == d) got.push_back(pulse_q[i]);
    n_checks++;
    if (got.size() != n) begin
      n_errs++; $display("FAIL %s pulse_count got=%0d want=%0d", nm, got.size(), n);
    end
    for (int k = 0; k < n && k < got.size(); k++) begin
      n_checks++;
      if (got[k].b !== msg[k]) begin
        n_errs++; $display("FAIL %s byte%0d got=%h want=%h", nm, k, got[k].b, msg[k]);
      end
      n_checks++;
      if (got[k].edge_n != last_edge + 1 + k * per(d)) begin
        n_errs++;
        $display("FAIL %s timing%0d got_edge=%0d want_edge=%0d", nm, k, got[k].edge_n,
                 last_edge + 1 + k * per(d));
      end
      n_checks++;
      if (got[k].len !== 64'(n)) begin
        n_errs++; $display("FAIL %s length%0d got=%0d want=%0d", nm, k, got[k].len, n);
      end
    end
    n_checks++;
    if (in_ready[d] !== 1'b0 || busy[d] !== 1'b1 || err_overflow[d] !== exp_err) begin
      n_errs++;
      $display("FAIL %s wait_state in_ready=%b busy=%b err=%b want 0/1/%b", nm, in_ready[d],
               busy[d], err_overflow[d], exp_err);
    end
  endtask

  task automatic ack(input int d, input int n, input string nm);
    repeat (5) begin
      @(negedge clk);
      n_checks++;
      if (in_ready[d] !== 1'b0 || done[d] !== 1'b0) begin
        n_errs++;
        $display("FAIL %s pre_ack in_ready=%b done=%b want 0/0", nm, in_ready[d], done[d]);
      end
    end
    hash_ready_i[d] = 1'b1;
    @(negedge clk);
    hash_ready_i[d] = 1'b0;
    n_checks++;
    if (done[d] !== 1'b1) begin
      n_errs++; $display("FAIL %s done_pulse got=%b want=1", nm, done[d]);
    end
    n_checks++;
    if (in_ready[d] !== 1'b1 || busy[d] !== 1'b0) begin
      n_errs++;
      $display("FAIL %s reload in_ready=%b busy=%b want 1/0", nm, in_ready[d], busy[d]);
    end
    @(negedge clk);
    n_checks++;
    if (done[d] !== 1'b0 || in_ready[d] !== 1'b1) begin
      n_errs++;
      $display("FAIL %s post_ack done=%b in_ready=%b want 0/1", nm, done[d], in_ready[d]);
    end
    n_checks++;
    if (msg_length[d] !== 64'(n)) begin
      n_errs++; $display("FAIL %s length_hold got=%0d want=%0d", nm, msg_length[d], n);
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b0; in_valid[d] = 1'b0; in_data[d] = 8'h00; in_last[d] = 1'b0;
      hash_ready_i[d] = 1'b0;
    end
    #2;
    rst[0] = 1'b1; rst[1] = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (in_ready[d] !== 1'b0 || msg_byte[d] !== 8'h00 || msg_valid[d] !== 1'b0 ||
          msg_length[d] !== 64'd0 || busy[d] !== 1'b0 || done[d] !== 1'b0 ||
          err_overflow[d] !== 1'b0) begin
        n_errs++;
        $display("FAIL reset_dut%0d rdy=%b byte=%h vld=%b len=%0d busy=%b done=%b err=%b want all 0",
                 d, in_ready[d], msg_byte[d], msg_valid[d], msg_length[d], busy[d], done[d],
                 err_overflow[d]);
      end
    end
    repeat (2) @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (in_ready[d] !== 1'b1 || busy[d] !== 1'b0) begin
        n_errs++;
        $display("FAIL reset_release_dut%0d in_ready=%b busy=%b want 1/0", d, in_ready[d], busy[d]);
      end
    end
  endtask

  task automatic test_abc();
    bq_t m;
    int le;
    m = '{8'h61, 8'h62, 8'h63};
    pulse_q.delete();
    send_msg(0, m, 1'b0, 1'b1, le);
    check_feed(0, m, le, 1'b0, "abc");
    ack(0, 3, "abc");
  endtask

  task automatic test_one_byte();
    bq_t m;
    int le;
    m = '{8'hFF};
    pulse_q.delete();
    send_msg(0, m, 1'b0, 1'b1, le);
    check_feed(0, m, le, 1'b0, "one_byte");
    ack(0, 1, "one_byte");
  endtask

  task automatic test_exact_depth();
    bq_t m;
    int le;
    m = '{8'hA5, 8'h3C, 8'h00, 8'hE7};
    pulse_q.delete();
    send_msg(0, m, 1'b0, 1'b1, le);
    check_feed(0, m, le, 1'b0, "exact_depth");
    ack(0, 4, "exact_depth");
  endtask

  task automatic test_random(input int d, input int iters, input string nm);
    bq_t m;
    int le;
    int n;
    for (int it = 0; it < iters; it++) begin
      n = $urandom_range(1, (d == 0) ? 4 : 16);
      m.delete();
      for (int k = 0; k < n; k++) m.push_back(8'($urandom));
      pulse_q.delete();
      send_msg(d, m, 1'b1, 1'b1, le);
      check_feed(d, m, le, 1'b0, nm);
      ack(d, n, nm);
    end
  endtask

  task automatic test_rst_mid();
    bq_t m;
    int le;
    int guard = 0;
    int np;
    m = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    pulse_q.delete();
    send_msg(1, m, 1'b0, 1'b1, le);
    while (count_p(1) < 2 && guard < 100) begin
      @(negedge clk); guard++;
    end
    n_checks++;
    if (count_p(1) != 2) begin
      n_errs++; $display("FAIL rst_mid pre_pulses got=%0d want=2", count_p(1));
    end
    @(negedge clk);
    #1 rst[1] = 1'b1;
    #1;
    n_checks++;
    if (in_ready[1] !== 1'b0 || msg_byte[1] !== 8'h00 || msg_valid[1] !== 1'b0 ||
        msg_length[1] !== 64'd0 || busy[1] !== 1'b0 || done[1] !== 1'b0 ||
        err_overflow[1] !== 1'b0) begin
      n_errs++;
      $display("FAIL rst_mid async rdy=%b byte=%h vld=%b len=%0d busy=%b done=%b err=%b want all 0",
               in_ready[1], msg_byte[1], msg_valid[1], msg_length[1], busy[1], done[1],
               err_overflow[1]);
    end
    repeat (2) @(negedge clk);
    rst[1] = 1'b0;
    np = count_p(1);
    repeat (8 * per(1)) @(negedge clk);
    n_checks++;
    if (count_p(1) != np) begin
      n_errs++; $display("FAIL rst_mid extra_pulses got=%0d want=%0d", count_p(1), np);
    end
    n_checks++;
    if (in_ready[1] !== 1'b1 || busy[1] !== 1'b0) begin
      n_errs++;
      $display("FAIL rst_mid idle in_ready=%b busy=%b want 1/0", in_ready[1], busy[1]);
    end
    m = '{8'hC0, 8'hDE, 8'h77};
    pulse_q.delete();
    send_msg(1, m, 1'b0, 1'b1, le);
    check_feed(1, m, le, 1'b0, "rst_mid_new");
    ack(1, 3, "rst_mid_new");
  endtask

  task automatic test_overflow();
    bq_t m;
    int le;
    pulse_q.delete();
    m = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_msg(0, m, 1'b0, 1'b0, le);
    n_checks++;
    if (err_overflow[0] !== 1'b1 || busy[0] !== 1'b1 || in_ready[0] !== 1'b1) begin
      n_errs++;
      $display("FAIL overflow drain err=%b busy=%b in_ready=%b want 1/1/1", err_overflow[0],
               busy[0], in_ready[0]);
    end
    m = '{8'h05, 8'h06};
    send_msg(0, m, 1'b0, 1'b1, le);
    n_checks++;
    if (err_overflow[0] !== 1'b1 || busy[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
      n_errs++;
      $display("FAIL overflow reload err=%b busy=%b in_ready=%b want 1/0/1", err_overflow[0],
               busy[0], in_ready[0]);
    end
    repeat (10) @(negedge clk);
    n_checks++;
    if (count_p(0) != 0) begin
      n_errs++; $display("FAIL overflow pulses got=%0d want=0", count_p(0));
    end
    m = '{8'h9A, 8'hBC};
    pulse_q.delete();
    send_msg(0, m, 1'b0, 1'b1, le);
    check_feed(0, m, le, 1'b1, "after_overflow");
    ack(0, 2, "after_overflow");
  endtask

  initial begin
    test_reset();
    test_abc();
    test_one_byte();
    test_exact_depth();
    test_random(0, 3, "back_to_back");
    test_random(1, 4, "period6_toggle");
    test_rst_mid();
    test_overflow();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time_limit reached");
    $fatal(1, "watchdog");
  end

endmodule
